// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO strobe-read side and valid/ready stream side of the stream reader.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
);
    localparam int LEVEL_W = $clog2(RD_LATENCY + 2);

    logic                  fifo_empty;
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] fifo_read_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [LEVEL_W-1:0]    buf_level;

    modport master (
        input  fifo_empty,
        input  fifo_read_data,
        input  m_ready,
        output fifo_read,
        output m_valid,
        output m_data,
        output buf_level
    );

    modport slave (
        output fifo_empty,
        output fifo_read_data,
        output m_ready,
        input  fifo_read,
        input  m_valid,
        input  m_data,
        input  buf_level
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: prefetches FIFO words into a skid buffer and presents them as a valid/ready stream.
// Optional beat/stall statistics ports are built when FIFO_READER_STATS_EN is defined.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fifo_stream_reader_if.master bus
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [15:0]          beat_count,
    output logic [15:0]          stall_count
`endif
);
    localparam int BUF_DEPTH = RD_LATENCY + 1;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W     = $clog2(BUF_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] buf_mem_r [BUF_DEPTH];
    logic [IDX_W-1:0]      head_r;
    logic [IDX_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      inflight_r;
    logic [RD_LATENCY-1:0] vpipe_r;

    logic                  pop_s;
    logic                  capture_s;
    logic                  fifo_read_s;
    logic                  m_valid_s;
    logic [CNT_W:0]        occupancy_s;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
    endfunction

    // Credit check: a read may issue only if its word is guaranteed a buffer slot on return.
    always_comb begin
        m_valid_s   = (count_r != {CNT_W{1'b0}});
        pop_s       = m_valid_s & bus.m_ready;
        capture_s   = vpipe_r[RD_LATENCY-1];
        occupancy_s = {1'b0, count_r} + {1'b0, inflight_r};
        if (!reset_n || bus.fifo_empty) begin
            fifo_read_s = 1'b0;
        end else if (occupancy_s < DEPTH_EXT) begin
            fifo_read_s = 1'b1;
        end else if (pop_s && (occupancy_s == DEPTH_EXT)) begin
            fifo_read_s = 1'b1;
        end else begin
            fifo_read_s = 1'b0;
        end
    end

    // Read-return tracking: valid shift pipe mirrors the RAM latency, inflight counts outstanding reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vpipe_r    <= {RD_LATENCY{1'b0}};
            inflight_r <= {CNT_W{1'b0}};
        end else begin
            vpipe_r[0] <= fifo_read_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vpipe_r[i] <= vpipe_r[i-1];
            end
            case ({fifo_read_s, capture_s})
                2'b10:   inflight_r <= inflight_r + CNT_W'(1);
                2'b01:   inflight_r <= inflight_r - CNT_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Skid buffer: circular store written at tail on capture, drained at head on pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            head_r  <= {IDX_W{1'b0}};
            tail_r  <= {IDX_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (capture_s) begin
                buf_mem_r[tail_r] <= bus.fifo_read_data;
                tail_r            <= next_idx(tail_r);
            end else begin
                tail_r            <= tail_r;
            end
            if (pop_s) begin
                head_r <= next_idx(head_r);
            end else begin
                head_r <= head_r;
            end
            case ({capture_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign bus.fifo_read = fifo_read_s;
    assign bus.m_valid   = m_valid_s;
    assign bus.m_data    = buf_mem_r[head_r];
    assign bus.buf_level = count_r;

`ifdef FIFO_READER_STATS_EN
    logic [15:0] beat_count_r;
    logic [15:0] stall_count_r;

    // Statistics: beat counter wraps, stall counter saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_count_r  <= 16'h0000;
            stall_count_r <= 16'h0000;
        end else begin
            if (pop_s) begin
                beat_count_r <= beat_count_r + 16'd1;
            end else begin
                beat_count_r <= beat_count_r;
            end
            if (m_valid_s && !bus.m_ready && (stall_count_r != 16'hFFFF)) begin
                stall_count_r <= stall_count_r + 16'd1;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign beat_count  = beat_count_r;
    assign stall_count = stall_count_r;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized bench with a queue-based FIFO model and an in-order scoreboard.
// Statistics checks are compiled in when FIFO_READER_STATS_EN is defined.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int RL = 1;
    localparam int BD = RL + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    fifo_stream_reader_if #(.DATA_WIDTH(DW), .RD_LATENCY(RL)) bus();

`ifdef FIFO_READER_STATS_EN
    logic [15:0] beat_count;
    logic [15:0] stall_count;
`endif

    fifo_stream_reader #(.DATA_WIDTH(DW), .RD_LATENCY(RL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef FIFO_READER_STATS_EN
        ,
        .beat_count  (beat_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] fq[$];      // words still inside the FIFO
    logic [DW-1:0] exp_q[$];   // words written and not yet delivered, in order

    logic          s_valid, s_read, s_ready;
    logic [DW-1:0] s_data;
    logic [1:0]    s_level;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    int            reads_issued, beats_done;
    longint        beats_total, stalls_total;
    int            rd_cnt, nb, first_c, last_c;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock: sample at negedge, check rules, then apply the FIFO's registered read after posedge.
    task automatic cycle();
        @(negedge clk);
        s_valid = bus.m_valid;
        s_read  = bus.fifo_read;
        s_ready = bus.m_ready;
        s_data  = bus.m_data;
        s_level = bus.buf_level;
        check("rd_when_empty", 64'(s_read & bus.fifo_empty), 64'd0);
        if (prev_stall) begin
            check("hold_valid", 64'(s_valid), 64'd1);
            check("hold_data", 64'(s_data), 64'(prev_data));
        end
        if (s_valid && s_ready) begin
            check("beat_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("beat_data", 64'(s_data), 64'(exp_q.pop_front()));
            beats_done++;
            beats_total++;
        end
        if (s_valid && !s_ready) stalls_total++;
        if (s_read) reads_issued++;
        check("credit", 64'((reads_issued - beats_done) <= BD), 64'd1);
        prev_stall = s_valid && !s_ready;
        prev_data  = s_data;
        @(posedge clk);
        #1;
        if (s_read && (fq.size() != 0)) bus.fifo_read_data = fq.pop_front();
        bus.fifo_empty = (fq.size() == 0);
    endtask

    // Reset (FIFO shares it): check outputs clear at once, optionally preload, release after posedge.
    task automatic reset_phase(input int n_pre);
        reset_n = 1'b0;
        #1;
        check("rst_read", 64'(bus.fifo_read), 64'd0);
        check("rst_valid", 64'(bus.m_valid), 64'd0);
        check("rst_data", 64'(bus.m_data), 64'd0);
        check("rst_level", 64'(bus.buf_level), 64'd0);
        fq.delete();
        exp_q.delete();
        bus.fifo_read_data = {DW{1'b0}};
        bus.fifo_empty     = 1'b1;
        bus.m_ready        = 1'b0;
        prev_stall   = 1'b0;
        reads_issued = 0;
        beats_done   = 0;
        beats_total  = 0;
        stalls_total = 0;
        for (int i = 0; i < n_pre; i++) push_word(DW'($urandom));
        repeat (2) @(posedge clk);
        #1;
        check("rst_read_held", 64'(bus.fifo_read), 64'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.fifo_empty     = 1'b1;
        bus.fifo_read_data = {DW{1'b0}};
        bus.m_ready        = 1'b0;
        @(posedge clk);
        #1;

        // 1: three preloaded words after reset, first beat two cycles after the first read
        reset_phase(3);
        bus.m_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            cycle();
            check("t1_valid", 64'(s_valid), 64'(c >= 2 && c <= 4));
            if (c == 0) check("t1_read0", 64'(s_read), 64'd1);
        end
        check("t1_drained", 64'(exp_q.size()), 64'd0);

        // 2: ten words streamed back-to-back
        for (int i = 0; i < 10; i++) push_word(DW'($urandom));
        rd_cnt = 0; nb = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (s_read) rd_cnt++;
            if (s_valid && s_ready) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                nb++;
            end
        end
        check("t2_reads", 64'(rd_cnt), 64'd10);
        check("t2_beats", 64'(nb), 64'd10);
        check("t2_no_gaps", 64'(last_c - first_c), 64'd9);

        // 3: consumer stalled, buffer fills then reads stop; drain keeps order
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(DW'($urandom));
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (c >= 3) check("t3_no_read", 64'(s_read), 64'd0);
        end
        check("t3_level", 64'(s_level), 64'(BD));
        bus.m_ready = 1'b1;
        for (int c = 0; c < 10; c++) cycle();
        check("t3_drained", 64'(exp_q.size()), 64'd0);
        check("t3_level_end", 64'(s_level), 64'd0);

        // 4: toggling ready with random sparse writes
        for (int c = 0; c < 400; c++) begin
            bus.m_ready = c[0];
            if ($urandom_range(0, 2) == 0) push_word(DW'($urandom));
            cycle();
        end
        bus.m_ready = 1'b1;
        for (int c = 0; c < 12; c++) cycle();
        check("t4_drained", 64'(exp_q.size()), 64'd0);

        // 5: reset mid-burst discards everything
        for (int i = 0; i < 8; i++) push_word(DW'($urandom));
        for (int c = 0; c < 4; c++) cycle();
        check("t5_midburst", 64'(s_valid), 64'd1);
        reset_phase(0);
        bus.m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            check("t5_no_stale", 64'(s_valid), 64'd0);
        end
        for (int i = 0; i < 4; i++) push_word(DW'($urandom));
        for (int c = 0; c < 10; c++) cycle();
        check("t5_after_ok", 64'(exp_q.size()), 64'd0);

`ifdef FIFO_READER_STATS_EN
        // 6: statistics counters
        reset_phase(0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 300; i++) push_word(DW'($urandom));
        for (int g = 0; g < 400 && beats_total < 300; g++) cycle();
        check("t6_beats_reached", 64'(beats_total), 64'd300);
        bus.m_ready = 1'b0;
        push_word(DW'($urandom));
        for (int g = 0; g < 20 && stalls_total < 5; g++) cycle();
        check("t6_stalls_reached", 64'(stalls_total), 64'd5);
        check("t6_beat_count", 64'(beat_count), 64'd300);
        check("t6_stall_count", 64'(stall_count), 64'd5);
        reset_phase(0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 65536; i++) push_word(DW'($urandom));
        for (int g = 0; g < 66000 && beats_total < 65536; g++) cycle();
        check("t6_wrap_reached", 64'(beats_total), 64'd65536);
        check("t6_beat_wrap", 64'(beat_count), 64'd0);
        check("t6_stall_none", 64'(stall_count), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
